circuit_2_prio_enc: RTL and testbench

- Registered highest-priority (MSB-first) encoder.
- Takes an N-bit request vector and outputs the binary index of the most-significant set bit, plus a flag telling whether any bit was set.
- Used as a small arbitration/index-extraction stage; the default configuration is the 4-to-2 encoder.
- Outputs are registered, one clock of latency, with an enable for hold.

---
 rtl/circuit_2_prio_enc.sv | 50 +++++
 tb/tb_circuit_2_prio_enc.sv | 134 +++++++++++++
 2 files changed

// File: rtl/circuit_2_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : circuit_2_prio_enc
//  Purpose  : Registered MSB-first priority encoder with capture enable.
//  Revision : 1.0  initial release
// ============================================================================
module circuit_2_prio_enc #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] x,
   output logic [W-1:0] y,
   output logic         y_valid
);

   logic [W-1:0] w_idx;
   logic         w_any;
   logic [W-1:0] r_y;
   logic         r_y_valid;

   // Ascending scan lets the highest set bit win; an all-zero x leaves index 0.
   always_comb begin
      w_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (x[i]) begin
            w_idx = W'(i);
         end
      end
   end

   assign w_any = |x;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y       <= '0;
         r_y_valid <= 1'b0;
      end else if (en) begin
         r_y       <= w_idx;
         r_y_valid <= w_any;
      end
   end

   assign y       = r_y;
   assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_circuit_2_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_circuit_2_prio_enc
//  Purpose  : Directed self-checking bench for the 4-to-2 registered encoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_circuit_2_prio_enc;

   localparam int c_n = 4;
   localparam int c_w = 2;

   logic           clk;
   logic           rst_n;
   logic           en;
   logic [c_n-1:0] x;
   logic [c_w-1:0] y;
   logic           y_valid;

   int n_checks;
   int n_errors;

   circuit_2_prio_enc #(.N(c_n)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .x       (x),
      .y       (y),
      .y_valid (y_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-written truth table for the default 4-bit configuration.
   function automatic logic [1:0] ref_idx(input logic [3:0] v);
      casez (v)
         4'b1???: ref_idx = 2'd3;
         4'b01??: ref_idx = 2'd2;
         4'b001?: ref_idx = 2'd1;
         default: ref_idx = 2'd0;
      endcase
   endfunction

   initial begin
      logic [1:0] exp_y [16];
      logic [3:0] rv;
      exp_y = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
      n_checks = 0;
      n_errors = 0;

      // Reset held with all requests active
      rst_n = 1'b0;
      en    = 1'b1;
      x     = 4'b1111;
      #2;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_y", 32'(y), 32'd0);
         check("rst_valid", 32'(y_valid), 32'd0);
      end
      rst_n = 1'b1;
      tick();
      check("post_rst_y", 32'(y), 32'd3);
      check("post_rst_valid", 32'(y_valid), 32'd1);

      // Exhaustive sweep, one value per clock
      for (int v = 0; v < 16; v++) begin
         x = 4'(v);
         tick();
         check($sformatf("sweep_y_%0d", v), 32'(y), 32'(exp_y[v]));
         check($sformatf("sweep_valid_%0d", v), 32'(y_valid), (v != 0) ? 32'd1 : 32'd0);
      end

      // Priority masking
      x = 4'b0110; tick(); check("mask_0110", 32'(y), 32'd2);
      x = 4'b1011; tick(); check("mask_1011", 32'(y), 32'd3);
      x = 4'b0011; tick(); check("mask_0011", 32'(y), 32'd1);

      // Enable hold
      x = 4'b0100; tick();
      check("hold_load", 32'(y), 32'd2);
      en = 1'b0;
      x  = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hold_y", 32'(y), 32'd2);
         check("hold_valid", 32'(y_valid), 32'd1);
      end
      en = 1'b1;
      tick();
      check("hold_release", 32'(y), 32'd3);

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check("async_y", 32'(y), 32'd0);
      check("async_valid", 32'(y_valid), 32'd0);
      rst_n = 1'b1;
      x = 4'b0010;
      tick();
      check("recover_y", 32'(y), 32'd1);
      check("recover_valid", 32'(y_valid), 32'd1);

      // Random values against the truth table, one cycle later
      for (int i = 0; i < 40; i++) begin
         rv = 4'($urandom_range(0, 15));
         x  = rv;
         tick();
         check($sformatf("rand_y_%0h", rv), 32'(y), 32'(ref_idx(rv)));
         check($sformatf("rand_valid_%0h", rv), 32'(y_valid), (rv != 4'd0) ? 32'd1 : 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
